vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Arbitrates a single-port, 1-cycle-latency video RAM between the pixel-fetch path of the VGA pipeline and up to NREQ game-logic requesters inside the scene logic. The video port has absolute priority, so display fetches are never delayed. Game requesters share the remaining cycles round-robin, and each one gets a sticky starvation flag. All RAM-side outputs are registered, so the block drops directly between the scene logic and the inferred block RAM.

## Interface
- NREQ, 4: number of game requesters (2..8)
- AW, 12: RAM address width
- DW, 12: RAM data width (4:4:4 RGB)
- MAX_WAIT, 1023: wait cycles before starve flag sets (fits 10 bits)

- clk  in  1  pixel clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- vid_req  in  1  video read request, no handshake
- vid_addr  in  AW  video read address
- vid_rvalid  out  1  video read data valid
- req  in  NREQ  per-requester access request, level
- we  in  NREQ  per-requester write enable (1=write, 0=read)
- addr  in  NREQ*AW  flattened addresses, requester i at [i*AW +: AW]
- wdata  in  NREQ*DW  flattened write data
- gnt  out  NREQ  one-hot grant pulse
- rvalid  out  NREQ  one-hot read-data-valid pulse (reads only)
- rdata  out  DW  read data for video and requesters, equal to mem_rdata
- starve  out  NREQ  sticky starvation flags
- mem_en, mem_we  out  1  RAM enable / write enable
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_en

## Operation
- Each cycle, the arbiter selects one winner from vid_req and the eligible req bits.
  - vid_req wins unconditionally.
  - Otherwise the first eligible requester at or after index rr_ptr+1 wins, searching with wrap-around.
- Eligible: req[i]=1 and gnt[i]=0 in the current cycle. A requester just granted is masked for one cycle, which gives it time to drop req.
- On a winner, the RAM outputs are registered next edge from the winner's inputs: mem_en=1, plus mem_we, mem_addr and mem_wdata.
  - Video: mem_we=0.
  - Requester: gnt[i]=1 is registered on the same edge, and rr_ptr updates to i.
- Video grants do not move rr_ptr.
- Read-tracking pipeline:
  - vid_rvalid=1 one cycle after a video mem_en.
  - rvalid[i]=1 one cycle after a requester read mem_en. No rvalid is generated for writes.
- Requester contract: hold req, we, addr and wdata stable until gnt is sampled high. Drop req or change the request in the gnt cycle.
- Starvation:
  - Per-requester wait counter, 10 bits, saturating.
  - Increments each cycle req[i]=1 and requester i does not win. Clears when it wins or when req[i]=0.
  - When the counter reaches MAX_WAIT, starve[i] sets and stays set until reset.
- Reset, asynchronous: rr_ptr=NREQ-1 so requester 0 is first. All counters are 0. mem_en, mem_we, gnt, rvalid, vid_rvalid and starve are all 0. mem_addr and mem_wdata are 0.

## Timing
- Cycle t: request sampled, winner chosen combinationally.
- Edge t+1: mem_en, mem_addr and gnt are high.
- Edge t+2: read data appears on mem_rdata / rdata, with vid_rvalid or rvalid[i] high.
- Read latency from request: 2 cycles.
- Video streaming: a new vid_addr every cycle gives a read every cycle and data every cycle, 2 cycles behind. While vid_req stays high, no requester is granted.
- Max requester throughput: one access per 2 cycles per requester. With all NREQ requesting and no video, each is served once every NREQ cycles when NREQ ≥ 2.
- Simultaneous events:
  - vid_req and req together: video wins, and the requester's counter increments.
  - Counter reaching MAX_WAIT in the same cycle as a win: the win clears the counter and starve does not set.
- Reset mid-access: pending rvalid and vid_rvalid are dropped, mem_en drops immediately, and requesters must re-request.

## Test plan
- Reset with req=4'b1111, vid_req=0 → gnt order 0,1,2,3,0 on consecutive cycles starting 1 cycle after release, with all outputs 0 before release.
- vid_req=1 for 640 cycles with vid_addr incrementing from 0, RAM preloaded data=addr → vid_rvalid high for 640 cycles starting 2 cycles after the first request, rdata=0..639 in order, gnt stays 0.
- Requester 2 writes addr 0x123 data 0xABC, then reads 0x123 → gnt[2] pulses twice, rvalid[2]=1 exactly once, 1 cycle after the read grant, with rdata=0xABC.
- req[1] held with vid_req=1 for 1100 cycles (MAX_WAIT=1023) → starve[1] rises after 1023 waiting cycles and stays 1 after req[1] drops and after a later grant.
- vid_req and req[0] asserted on the same cycle → video granted first, gnt[0] one cycle later (once vid_req=0), rr_ptr unchanged by the video grant.
- rst_n pulsed low while a read is in flight → rvalid, mem_en and gnt are 0 from the reset assertion onward, and a post-reset req[3] is granted after requesters 0..2 when all four request.

Source files
------------

// File: rtl/vram_arbiter.sv
// ============================================================================
// Module   : vram_arbiter
// Purpose  : Shares one single-port, 1-cycle-latency video RAM between the
//            VGA pixel-fetch path and NREQ game-logic requesters. Video
//            accesses always win. Requesters share the remaining cycles
//            round-robin. Each requester has a sticky starvation flag.
//            All RAM-side outputs are registered.
// Ports    :
//   clk, rst_n              clock, asynchronous active-low reset
//   vid_req, vid_addr       video read request and address
//   vid_rvalid              video read data valid (2 cycles after request)
//   req, we, addr, wdata    per-requester request, write enable, address, data
//   gnt, rvalid             one-hot grant pulse, one-hot read-data-valid pulse
//   rdata                   read data (pass-through of mem_rdata)
//   starve                  sticky per-requester starvation flags
//   mem_en, mem_we          RAM enable and write enable
//   mem_addr, mem_wdata     RAM address and write data
//   mem_rdata               RAM read data, valid 1 cycle after mem_en
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vram_arbiter #(
  parameter int NREQ     = 4,
  parameter int AW       = 12,
  parameter int DW       = 12,
  parameter int MAX_WAIT = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vid_req,
  input  logic [AW-1:0]      vid_addr,
  output logic               vid_rvalid,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    we,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic [NREQ-1:0]    starve,
  output logic               mem_en,
  output logic               mem_we,
  output logic [AW-1:0]      mem_addr,
  output logic [DW-1:0]      mem_wdata,
  input  logic [DW-1:0]      mem_rdata
);

  localparam int          PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW:0] NREQ_W    = (PW+1)'(NREQ);
  // A waiting increment taken from this value lands on MAX_WAIT.
  localparam logic [9:0]  STARVE_AT = 10'(MAX_WAIT - 1);
  localparam logic [9:0]  CNT_SAT   = 10'h3FF;

  logic [PW-1:0]   rr_ptr;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [PW-1:0]   win_idx;
  logic [PW:0]     cand;
  logic [NREQ-1:0] win_req;
  logic [9:0]      wait_cnt [NREQ];

  // A requester granted last cycle is masked so it has time to drop req.
  assign elig  = req & ~gnt;
  assign rdata = mem_rdata;

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!found && elig[cand[PW-1:0]]) begin
        found   = 1'b1;
        win_idx = cand[PW-1:0];
      end
    end
  end

  // One-hot requester winner; empty whenever video takes the slot.
  assign win_req = (!vid_req && found) ? (NREQ'(1) << win_idx) : '0;

  // RAM port, grants and read-tracking pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr     <= PW'(NREQ - 1);
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      gnt        <= '0;
      rvalid     <= '0;
      vid_rvalid <= 1'b0;
    end else begin
      // A video access is the only kind of access with no grant bit set.
      vid_rvalid <= mem_en && (gnt == '0);
      rvalid     <= (mem_en && !mem_we) ? gnt : '0;
      if (vid_req) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= vid_addr;
        mem_wdata <= '0;
        gnt       <= '0;
      end else if (found) begin
        mem_en    <= 1'b1;
        mem_we    <= we[win_idx];
        mem_addr  <= addr[win_idx*AW +: AW];
        mem_wdata <= wdata[win_idx*DW +: DW];
        gnt       <= win_req;
        rr_ptr    <= win_idx;
      end else begin
        mem_en <= 1'b0;
        mem_we <= 1'b0;
        gnt    <= '0;
      end
    end
  end

  // Wait counters and sticky starvation flags. A win in the same cycle the
  // counter would reach MAX_WAIT clears it instead, so starve stays low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve <= '0;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || win_req[i]) begin
          wait_cnt[i] <= '0;
        end else begin
          if (wait_cnt[i] != CNT_SAT) begin
            wait_cnt[i] <= wait_cnt[i] + 10'd1;
          end
          if (wait_cnt[i] >= STARVE_AT) begin
            starve[i] <= 1'b1;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// ============================================================================
// Module   : tb_vram_arbiter
// Purpose  : Directed self-checking bench for vram_arbiter with a behavioural
//            1-cycle-latency block RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vram_arbiter;

  localparam int NREQ     = 4;
  localparam int AW       = 12;
  localparam int DW       = 12;
  localparam int MAX_WAIT = 1023;

  logic               clk;
  logic               rst_n;
  logic               vid_req;
  logic [AW-1:0]      vid_addr;
  logic               vid_rvalid;
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    we;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*DW-1:0] wdata;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    rvalid;
  logic [DW-1:0]      rdata;
  logic [NREQ-1:0]    starve;
  logic               mem_en;
  logic               mem_we;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_wdata;
  logic [DW-1:0]      mem_rdata;

  logic [DW-1:0] ram [1<<AW];

  int tests;
  int fails;

  vram_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .starve(starve),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Raise a request, wait (bounded) for its grant, check the RAM port, drop req.
  task automatic do_access(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    logic seen;
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (gnt[i]) seen = 1'b1;
    end
    check_eq("acc_gnt_seen", 32'(seen), 32'd1);
    check_eq("acc_mem_addr", 32'(mem_addr), 32'(a));
    check_eq("acc_mem_we",   32'(mem_we), 32'(w));
    if (w) check_eq("acc_mem_wdata", 32'(mem_wdata), 32'(d));
    req[i] = 1'b0;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    for (int a = 0; a < (1<<AW); a++) begin
      ram[a] = DW'(a);
    end
    rst_n    = 1'b0;
    vid_req  = 1'b0;
    vid_addr = '0;
    we       = '0;
    wdata    = '0;
    req      = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      addr[i*AW +: AW] = AW'(12'h010 + i);
    end

    // ---- Reset state, then round-robin order 0,1,2,3,0 ----
    repeat (3) @(negedge clk);
    check_eq("rst_gnt",        32'(gnt), 32'd0);
    check_eq("rst_mem_en",     32'(mem_en), 32'd0);
    check_eq("rst_mem_we",     32'(mem_we), 32'd0);
    check_eq("rst_mem_addr",   32'(mem_addr), 32'd0);
    check_eq("rst_mem_wdata",  32'(mem_wdata), 32'd0);
    check_eq("rst_rvalid",     32'(rvalid), 32'd0);
    check_eq("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
    check_eq("rst_starve",     32'(starve), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("rr_gnt",      32'(gnt), 32'(1 << (k % 4)));
      check_eq("rr_mem_en",   32'(mem_en), 32'd1);
      check_eq("rr_mem_addr", 32'(mem_addr), 32'(12'h010 + (k % 4)));
      if (k > 0) check_eq("rr_rvalid", 32'(rvalid), 32'(1 << ((k - 1) % 4)));
    end
    req = '0;
    @(negedge clk);
    check_eq("rr_last_rvalid", 32'(rvalid), 32'd1);
    check_eq("rr_idle_gnt",    32'(gnt), 32'd0);
    @(negedge clk);
    check_eq("rr_idle_mem_en", 32'(mem_en), 32'd0);

    // ---- Video streaming 640 reads, requester 3 locked out ----
    req = 4'b1000;
    for (int i = 0; i < 642; i++) begin
      vid_req  = (i < 640);
      vid_addr = i[AW-1:0];
      if (i == 640) req = '0;
      @(negedge clk);
      check_eq("vid_gnt", 32'(gnt), 32'd0);
      if (i >= 1 && i <= 640) begin
        check_eq("vid_rvalid", 32'(vid_rvalid), 32'd1);
        check_eq("vid_rdata",  32'(rdata), 32'(i - 1));
      end else if (i == 641) begin
        check_eq("vid_rvalid_end", 32'(vid_rvalid), 32'd0);
      end
    end

    // ---- Requester 2 write then read back ----
    do_access(2, 1'b1, 12'h123, 12'hABC);
    @(negedge clk);
    check_eq("wr_no_rvalid", 32'(rvalid), 32'd0);
    check_eq("wr_gnt_drop",  32'(gnt), 32'd0);
    do_access(2, 1'b0, 12'h123, 12'h000);
    @(negedge clk);
    check_eq("rd_rvalid", 32'(rvalid), 32'b0100);
    check_eq("rd_rdata",  32'(rdata), 32'hABC);
    check_eq("rd_gnt_drop", 32'(gnt), 32'd0);
    @(negedge clk);
    check_eq("rd_rvalid_once", 32'(rvalid), 32'd0);

    // ---- Starvation of requester 1 behind continuous video ----
    vid_req  = 1'b1;
    vid_addr = 12'h000;
    req[1]   = 1'b1;
    we[1]    = 1'b0;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (c == 1022) check_eq("starve_before", 32'(starve), 32'd0);
      if (c == 1023) check_eq("starve_set",    32'(starve), 32'b0010);
      if (c == 1100) check_eq("starve_gnt",    32'(gnt), 32'd0);
    end
    vid_req = 1'b0;
    do_access(1, 1'b0, 12'h010, 12'h000);
    @(negedge clk);
    check_eq("starve_sticky", 32'(starve), 32'b0010);

    // ---- Video and requesters together; video does not move rr_ptr ----
    // rr_ptr is 1 here, so requester 2 must precede requester 0.
    vid_req = 1'b1;
    req     = 4'b0101;
    @(negedge clk);
    check_eq("sim_vid_gnt",    32'(gnt), 32'd0);
    check_eq("sim_vid_mem_en", 32'(mem_en), 32'd1);
    check_eq("sim_vid_mem_we", 32'(mem_we), 32'd0);
    vid_req = 1'b0;
    @(negedge clk);
    check_eq("sim_gnt2", 32'(gnt), 32'b0100);
    req[2] = 1'b0;
    @(negedge clk);
    check_eq("sim_gnt0", 32'(gnt), 32'b0001);
    check_eq("sim_vid_rvalid_gone", 32'(vid_rvalid), 32'd0);
    req = '0;
    @(negedge clk);
    check_eq("sim_idle", 32'(gnt), 32'd0);

    // ---- Reset with a read in flight ----
    req[1] = 1'b1;
    we[1]  = 1'b0;
    @(negedge clk);
    check_eq("mid_gnt", 32'(gnt), 32'b0010);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check_eq("mid_rst_gnt",    32'(gnt), 32'd0);
    check_eq("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check_eq("mid_rst_starve", 32'(starve), 32'd0);
    @(negedge clk);
    check_eq("mid_rst_rvalid2", 32'(rvalid), 32'd0);
    check_eq("mid_rst_vid",     32'(vid_rvalid), 32'd0);
    req   = 4'b1111;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("post_rst_gnt", 32'(gnt), 32'(1 << k));
    end
    req = '0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
